// File: rtl/cic_sequencer.sv
// cic_sequencer
//   Run-control front end for a CIC decimator. Paces source samples into the
//   CIC at a programmable rate, holds the CIC in reset outside a run, pushes
//   zero samples through the pipeline after stop, and holds each decimated
//   output in a valid/ack register.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   start, stop, div              run control; div = input period - 1, latched on start
//   src_data/src_valid/src_ready  sample source (src_ready is combinational)
//   cic_rst/cic_in/cic_valid      drive to the CIC instance (registered)
//   cic_out/cic_ready             CIC output stream
//   out_data/out_valid/out_ack    held decimated output to the consumer
//   busy                          sequencer not idle
//   underrun, overrun             sticky error flags, cleared on rst or run start
//   sample_count                  outputs captured since last start (wraps)
//
// state  | meaning
// IDLE   | CIC held in reset, waiting for start
// CLR    | one cycle: CIC reset, flags/counter cleared, tick counter loaded
// RUN    | samples paced into the CIC once every div_q+1 cycles
// DRAIN  | zero samples pushed on each tick until DRAIN have been sent
module cic_sequencer #(
  parameter int BITS     = 10,
  parameter int N        = 2,
  parameter int DIV_BITS = 8,
  parameter int DRAIN    = 2 * N,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [DIV_BITS-1:0] div,
  input  logic [BITS-1:0]     src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic                cic_rst,
  output logic [BITS-1:0]     cic_in,
  output logic                cic_valid,
  input  logic [BITS-1:0]     cic_out,
  input  logic                cic_ready,
  output logic [BITS-1:0]     out_data,
  output logic                out_valid,
  input  logic                out_ack,
  output logic                busy,
  output logic                underrun,
  output logic                overrun,
  output logic [CNT_BITS-1:0] sample_count
);

  // Wide enough to hold DRAIN itself; at least one bit when DRAIN is 0.
  localparam int DRN_BITS = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [DIV_BITS-1:0] tick_cnt_q, tick_cnt_d;
  logic [DRN_BITS-1:0] drain_cnt_q, drain_cnt_d;
  logic                cic_rst_q, cic_rst_d;
  logic [BITS-1:0]     cic_in_q, cic_in_d;
  logic                cic_valid_q, cic_valid_d;
  logic [BITS-1:0]     out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;
  logic [CNT_BITS-1:0] sample_count_q, sample_count_d;

  logic tick;
  logic active;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign tick   = active && (tick_cnt_q == '0);

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    tick_cnt_d     = tick_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    cic_in_d       = cic_in_q;
    cic_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    underrun_d     = underrun_q;
    overrun_d      = overrun_q;
    sample_count_d = sample_count_q;

    // Tick counter free-runs through RUN and DRAIN so drain strobes keep the
    // same cadence as the run.
    if (active) begin
      tick_cnt_d = tick ? div_q : (tick_cnt_q - DIV_BITS'(1));
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          div_d   = div;
        end
      end
      S_CLR: begin
        tick_cnt_d = div_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (tick) begin
          cic_valid_d = 1'b1;
          cic_in_d    = src_valid ? src_data : '0;
          if (!src_valid) begin
            underrun_d = 1'b1;
          end
        end
        if (stop) begin
          if (DRAIN == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRN_BITS'(DRAIN);
          end
        end
      end
      S_DRAIN: begin
        if (tick) begin
          cic_valid_d = 1'b1;
          cic_in_d    = '0;
          drain_cnt_d = drain_cnt_q - DRN_BITS'(1);
          if (drain_cnt_q == DRN_BITS'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output holding register. Capture stays enabled after the run ends so
    // samples still in the CIC pipeline reach the consumer.
    if (state_q == S_CLR) begin
      out_valid_d    = 1'b0;
      sample_count_d = '0;
    end else if (cic_ready && (!out_valid_q || out_ack)) begin
      out_data_d     = cic_out;
      out_valid_d    = 1'b1;
      sample_count_d = sample_count_q + CNT_BITS'(1);
    end else begin
      // Here cic_ready implies out_valid && !out_ack: the new sample is lost.
      if (cic_ready) begin
        overrun_d = 1'b1;
      end
      if (out_ack) begin
        out_valid_d = 1'b0;
      end
    end

    // Registered from the next state so cic_rst lines up with IDLE/CLR.
    cic_rst_d = (state_d == S_IDLE) || (state_d == S_CLR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      tick_cnt_q     <= '0;
      drain_cnt_q    <= '0;
      cic_rst_q      <= 1'b1;
      cic_in_q       <= '0;
      cic_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      tick_cnt_q     <= tick_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      cic_rst_q      <= cic_rst_d;
      cic_in_q       <= cic_in_d;
      cic_valid_q    <= cic_valid_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign src_ready    = (state_q == S_RUN) && tick;
  assign cic_rst      = cic_rst_q;
  assign cic_in       = cic_in_q;
  assign cic_valid    = cic_valid_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;
  assign sample_count = sample_count_q;

endmodule
